// File: rtl/cla_seq_ctrl.sv
// Sequential W-bit add/subtract controller that drives an external registered
// 4-bit CLA slice one nibble at a time, LSB nibble first, rippling the carry.
module cla_seq_ctrl #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [4*NIB-1:0] opa,
  input  logic [4*NIB-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [4*NIB-1:0] result,
  output logic             cout,
  output logic             add_en,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [4:0]       add_q
);

  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                 state, state_nxt;
  logic [NIB-1:0][3:0]    a_q, b_q, res_q;
  logic                   sub_q;
  logic                   carry_q;
  logic                   cout_q;
  logic [IDX_W-1:0]       idx_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    add_en    = 1'b0;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        add_en    = 1'b1;
        add_a     = a_q[idx_q];
        add_b     = sub_q ? ~b_q[idx_q] : b_q[idx_q];
        add_cin   = carry_q;
        state_nxt = WAIT;
      end
      WAIT: begin
        state_nxt = (idx_q == LAST_IDX) ? DONE : ISSUE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: operand copies carry no reset; they are always reloaded on an
  // accepted start before any step reads them.
  always_ff @(posedge clk) begin
    if (state == IDLE && start && !reset) begin
      a_q   <= opa;
      b_q   <= opb;
      sub_q <= op_sub;
    end
  end

  // The slice output is consumed only in WAIT, so add_q is never looked at
  // while in reset or in the IDLE cycle that follows it.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx_q   <= '0;
            carry_q <= op_sub;
          end
        end
        WAIT: begin
          res_q[idx_q] <= add_q[3:0];
          carry_q      <= add_q[4];
          if (idx_q == LAST_IDX) cout_q <= add_q[4];
          else                   idx_q  <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign result = res_q;
  assign cout   = cout_q;

endmodule
